// File: rtl/sn_generator.sv
// sn_generator: LFSR-compare stochastic bitstream source with a small register file.
// One stream of LENGTH bits is emitted per START, one bit per cycle while in RUN.
module sn_generator #(
    parameter logic MODE = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [1:0]  ADDR,
    input  logic [31:0] DATA_IN,
    input  logic        DATA_WE,
    input  logic        START,
    output logic [31:0] DATA_OUT,
    output logic        SN_OUT_P,
    output logic        SN_OUT_N,
    output logic        VALID,
    output logic        BUSY,
    output logic        DONE
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state_q;
    logic [15:0] value_q, seed_q, length_q, lfsr_q, remain_q;
    logic        done_q;
    logic        run, cfg_we, abort, clr, bit_p, unused_bits;
    assign run         = state_q == RUN;
    assign cfg_we      = DATA_WE && !run;
    assign abort       = DATA_WE && ADDR == 2'd3 && DATA_IN[0];
    assign clr         = DATA_WE && ADDR == 2'd3 && DATA_IN[1];
    assign bit_p       = lfsr_q <= value_q;
    assign unused_bits = ^DATA_IN[31:16];
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state_q  <= IDLE;
            value_q  <= '0;
            seed_q   <= '0;
            length_q <= '0;
            lfsr_q   <= 16'hACE1;
            remain_q <= '0;
            done_q   <= 1'b0;
        end else begin
            if (cfg_we && ADDR == 2'd0) value_q <= DATA_IN[15:0];
            if (cfg_we && ADDR == 2'd1) seed_q <= DATA_IN[15:0];
            if (cfg_we && ADDR == 2'd2) length_q <= DATA_IN[15:0];
            if (clr) done_q <= 1'b0;
            // abort outranks both a pending START and the natural end of a stream
            if (abort) begin
                state_q <= IDLE;
            end else if (!run) begin
                if (START && length_q == '0) begin
                    done_q <= 1'b1;
                end else if (START) begin
                    state_q  <= RUN;
                    lfsr_q   <= seed_q == '0 ? 16'hACE1 : seed_q;
                    remain_q <= length_q;
                    done_q   <= 1'b0;
                end
            end else begin
                lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                remain_q <= remain_q - 16'd1;
                if (remain_q == 16'd1) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
            end
        end
    end
    assign VALID    = run;
    assign BUSY     = run;
    assign DONE     = done_q;
    assign SN_OUT_P = run && bit_p;
    assign SN_OUT_N = MODE && run && !bit_p;
    always_comb begin
        DATA_OUT = ADDR == 2'd0 ? {16'b0, value_q} :
                   ADDR == 2'd1 ? {16'b0, seed_q} :
                   ADDR == 2'd2 ? {16'b0, length_q} :
                   {29'b0, run, done_q, run};
    end
endmodule

// File: tb/tb_sn_generator.sv
// tb_sn_generator: randomized and directed checks of sn_generator (bipolar mode)
// against a sequence-level LFSR/compare reference model.
module tb_sn_generator;
    logic        CLK = 1'b0;
    logic        RST_X = 1'b0;
    logic [1:0]  ADDR = '0;
    logic [31:0] DATA_IN = '0;
    logic        DATA_WE = 1'b0;
    logic        START = 1'b0;
    logic [31:0] DATA_OUT;
    logic        SN_OUT_P, SN_OUT_N, VALID, BUSY, DONE;
    int          n_chk = 0;
    int          n_err = 0;

    sn_generator #(.MODE(1'b1)) dut (
        .CLK(CLK), .RST_X(RST_X), .ADDR(ADDR), .DATA_IN(DATA_IN), .DATA_WE(DATA_WE),
        .START(START), .DATA_OUT(DATA_OUT), .SN_OUT_P(SN_OUT_P), .SN_OUT_N(SN_OUT_N),
        .VALID(VALID), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        ADDR = a;
        DATA_IN = d;
        DATA_WE = 1'b1;
        tick();
        DATA_WE = 1'b0;
    endtask

    // successor of a state in the x^16+x^14+x^13+x^11+1 Fibonacci sequence
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        int fb;
        fb = ((x >> 15) + (x >> 13) + (x >> 12) + (x >> 10)) % 2;
        return 16'((int'(x) * 2) % 65536 + fb);
    endfunction

    task automatic rd_all_zero(input string tag);
        for (int a = 0; a < 4; a++) begin
            ADDR = 2'(a);
            #1;
            chk($sformatf("%s_reg%0d", tag, a), DATA_OUT, 32'd0);
        end
        chk({tag, "_outs"}, {27'd0, VALID, BUSY, DONE, SN_OUT_P, SN_OUT_N}, 32'd0);
    endtask

    task automatic stream(input string tag, input logic [15:0] v, input logic [15:0] s,
                          input logic [15:0] l, input logic poke, output int ones);
        logic [15:0] x;
        logic        e;
        int          bad, vcnt;
        wr(2'd0, {16'd0, v});
        wr(2'd1, {16'd0, s});
        wr(2'd2, {16'd0, l});
        ADDR = 2'd3;
        x = s == 0 ? 16'hACE1 : s;
        bad = 0;
        vcnt = 0;
        ones = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < int'(l); i++) begin
            e = x <= v;
            vcnt += int'(VALID);
            ones += int'(SN_OUT_P);
            if (!BUSY || DONE || DATA_OUT !== 32'd5) bad++;
            if (SN_OUT_P !== e || SN_OUT_N !== !e) bad++;
            x = lfsr_next(x);
            START = poke && i == int'(l) / 2;
            tick();
            START = 1'b0;
        end
        chk({tag, "_valid_cycles"}, vcnt, {16'd0, l});
        chk({tag, "_bit_errs"}, bad, 32'd0);
        chk({tag, "_end_state"}, {29'd0, VALID, BUSY, DONE}, 32'd1);
    endtask

    initial begin
        int ones;
        logic [15:0] v, s, l;
        tick();
        tick();
        rd_all_zero("reset");
        RST_X = 1'b1;
        tick();

        stream("basic", 16'h8000, 16'h0001, 16'd8, 1'b0, ones);
        stream("zero_val", 16'h0000, 16'h1234, 16'd100, 1'b0, ones);
        chk("zero_val_ones", ones, 32'd0);
        stream("full_val", 16'hFFFF, 16'h0000, 16'd100, 1'b1, ones);
        chk("full_val_ones", ones, 32'd100);

        wr(2'd2, 32'd0);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("len0_valid", VALID, 1'b0);
        chk("len0_done", DONE, 1'b1);
        wr(2'd3, 32'd2);
        chk("done_clear", DONE, 1'b0);

        wr(2'd2, 32'd50);
        ADDR = 2'd3;
        DATA_IN = 32'd1;
        DATA_WE = 1'b1;
        START = 1'b1;
        tick();
        DATA_WE = 1'b0;
        START = 1'b0;
        chk("abort_vs_start", {30'd0, VALID, DONE}, 32'd0);

        wr(2'd0, 32'h0000_3C3C);
        wr(2'd2, 32'd1000);
        START = 1'b1;
        tick();
        START = 1'b0;
        wr(2'd0, 32'h0000_1234);
        repeat (8) tick();
        chk("abort_pre_valid", VALID, 1'b1);
        wr(2'd3, 32'd1);
        chk("abort_outs", {30'd0, VALID, DONE}, 32'd0);
        ADDR = 2'd0;
        #1;
        chk("run_write_ignored", DATA_OUT, 32'h0000_3C3C);

        wr(2'd2, 32'd20);
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (4) tick();
        chk("rst_pre_valid", VALID, 1'b1);
        RST_X = 1'b0;
        tick();
        RST_X = 1'b1;
        rd_all_zero("mid_reset");

        for (int k = 0; k < 8; k++) begin
            v = 16'($urandom);
            s = k % 3 == 0 ? 16'd0 : 16'($urandom);
            l = 16'($urandom_range(1, 200));
            stream($sformatf("rand%0d", k), v, s, l, 1'($urandom), ones);
        end

        stream("period", 16'h4000, 16'($urandom), 16'hFFFF, 1'b0, ones);
        chk("period_ones", ones, 32'd16384);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sn_generator.md
SN_GENERATOR -- requirements
Module: sn_generator

Interface
- REQ-001: Parameter MODE, default 1'd0: 0 = unipolar (SN_OUT_N held 0); 1 = bipolar (SN_OUT_N = ~SN_OUT_P while VALID).
- REQ-002: CLK  input  1  system clock; all state updates on rising edge.
- REQ-003: RST_X  input  1  reset, synchronous and active-low.
- REQ-004: ADDR  input  2  register select: 0 = VALUE, 1 = SEED, 2 = LENGTH, 3 = CTRL/STATUS.
- REQ-005: DATA_IN  input  32  write data; only bits [15:0] are used for registers 0..2.
- REQ-006: DATA_WE  input  1  register write strobe, one write per asserted cycle.
- REQ-007: START  input  1  single-cycle request to emit one bitstream.
- REQ-008: DATA_OUT  output  32  combinational readback of register selected by ADDR.
- REQ-009: SN_OUT_P  output  1  stochastic bit, positive line, feeds the downstream ones-counter.
- REQ-010: SN_OUT_N  output  1  negative line per MODE.
- REQ-011: VALID  output  1  high exactly on cycles carrying a stream bit; drives downstream EN.
- REQ-012: BUSY  output  1  high while in RUN.
- REQ-013: DONE  output  1  sticky completion flag.

Function
- REQ-014: Registers VALUE[15:0], SEED[15:0] and LENGTH[15:0] are written when DATA_WE=1, ADDR matches and state is IDLE; such writes in RUN are ignored.
- REQ-015: DATA_OUT reads {16'b0, reg} for ADDR 0..2, and {29'b0, state==RUN, DONE, BUSY} for ADDR 3.
- REQ-016: The write at ADDR 3 with DATA_IN[0]=1 is an ABORT in any state: RUN -> IDLE next cycle, DONE unchanged.
- REQ-017: The write at ADDR 3 with DATA_IN[1]=1 clears DONE.
- REQ-018: FSM states: IDLE, RUN.
- REQ-019: IDLE -> RUN when START=1 and LENGTH!=0; START with LENGTH=0 sets DONE and stays IDLE.
- REQ-020: On IDLE -> RUN: LFSR loads SEED, or 16'hACE1 if SEED=0; counter REMAIN loads LENGTH; DONE clears.
- REQ-021: LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left, new bit[0] = b15^b13^b12^b10; it advances once per RUN cycle.
- REQ-022: In RUN: VALID=1, BUSY=1, SN_OUT_P = (LFSR <= VALUE), unsigned 16-bit compare on the current LFSR value.
- REQ-023: The first stream bit appears in the cycle after START is sampled (latency 1), and exactly LENGTH VALID cycles are produced back-to-back.
- REQ-024: REMAIN decrements each RUN cycle; on the cycle with REMAIN=1, the next state is IDLE and DONE is set.
- REQ-025: Outside RUN: VALID=0, BUSY=0, SN_OUT_P=0, SN_OUT_N=0.
- REQ-026: START during RUN is ignored.
- REQ-027: ABORT and START in the same cycle: ABORT wins, next state is IDLE.
- REQ-028: Since the LFSR never holds 0, VALUE=0 yields all zeros and VALUE=16'hFFFF yields all ones.
- REQ-029: Over LENGTH=65535 (full period) the number of ones equals VALUE exactly, for VALUE in 1..65535.

Reset
- REQ-030: While RST_X=0 at a clock edge: state=IDLE, VALUE=0, SEED=0, LENGTH=0, LFSR=16'hACE1, REMAIN=0, DONE=0; hence VALID=BUSY=SN_OUT_P=SN_OUT_N=0.
- REQ-031: Reset asserted mid-RUN terminates the stream at the next edge with no further VALID cycle.

Verification
- REQ-032: VALUE=0x8000, SEED=0x0001, LENGTH=8, START -> VALID high cycles 1..8 after START, BUSY matches, DONE rises with VALID falling, bits match a reference LFSR model.
- REQ-033: VALUE=0x4000, LENGTH=65535 (0xFFFF), START -> exactly 16384 ones on SN_OUT_P over 65535 VALID cycles.
- REQ-034: VALUE=0 and then VALUE=0xFFFF, LENGTH=100 -> 0 ones and 100 ones respectively; with MODE=1, SN_OUT_N is the complement on all 100 cycles.
- REQ-035: LENGTH=0, START -> no VALID cycles, DONE=1 next cycle; write ADDR3=0x2 -> DONE=0.
- REQ-036: LENGTH=1000, ABORT write at VALID cycle 10 -> VALID low from the next cycle, DONE=0, and a VALUE write during RUN reads back unchanged.
- REQ-037: RST_X=0 for one cycle at VALID cycle 5 of LENGTH=20 -> all outputs 0 the next cycle, all registers read back 0.
